// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the sigma-delta decimation controller.
package sd_ctrl_pkg;

   // Controller states: idle, start-up transient discard, normal operation
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } sd_state_t;

   // Number of decimated captures thrown away while the Sinc3 filter settles
   localparam int SD_SETTLE_COUNT = 3;

   // Depth of the decimated-sample output buffer
   localparam int SD_FIFO_DEPTH = 2;

endpackage

// File: rtl/sd_sample_fifo.sv
// Two-entry first-word-fall-through buffer for decimated samples.
// The head entry is held in its own register so dout is a plain flop output.
module sd_sample_fifo
   import sd_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int CW = $clog2(SD_FIFO_DEPTH + 1);

   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] head_reg;
   logic [WIDTH-1:0] tail_reg;
   logic             do_push;
   logic             do_pop;

   // Qualify requests: a pop needs data, a push needs room (or a same-cycle pop)
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   // Occupancy and storage update; a full buffer may pop and push together
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
      end else begin
         case (count_reg)
            CW'(0): begin
               if (do_push) begin
                  head_reg  <= din;
                  count_reg <= CW'(1);
               end
            end
            CW'(1): begin
               if (do_push && do_pop) begin
                  head_reg <= din;
               end else if (do_push) begin
                  tail_reg  <= din;
                  count_reg <= CW'(2);
               end else if (do_pop) begin
                  count_reg <= CW'(0);
               end
            end
            default: begin
               if (do_pop) begin
                  head_reg <= tail_reg;
                  if (do_push) begin
                     tail_reg <= din;
                  end else begin
                     count_reg <= CW'(1);
                  end
               end
            end
         endcase
      end
   end

   assign dout  = head_reg;
   assign full  = (count_reg == CW'(SD_FIFO_DEPTH));
   assign empty = (count_reg == CW'(0));

endmodule

// File: rtl/sd_decim_ctrl.sv
// Sigma-delta modulator / Sinc3 decimator sequencer.
// Generates the shared clock enable, locates decimation points, captures the
// filter output into a small buffer and presents it on a valid/ready port.
// Build option: define SD_DECIM_CTRL_SETTLE_EN to discard the first filter
// outputs after start while the Sinc3 transient dies out.
module sd_decim_ctrl
   import sd_ctrl_pkg::*;
#(
   parameter int OSR        = 32,
   parameter int FILT_WIDTH = 3 * $clog2(OSR) + 1,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [DIV_WIDTH-1:0]  div,
   input  logic [FILT_WIDTH-1:0] filtIn,
   output logic                  en,
   output logic [FILT_WIDTH-1:0] sampleOut,
   output logic                  sampleValid,
   input  logic                  sampleReady,
   output logic                  busy,
   output logic                  overflow
);

   localparam int PW = $clog2(OSR);

   sd_state_t            state_reg, state_next;
   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] div_cnt_reg;
   logic [PW-1:0]        phase_reg;
   logic                 cap_reg;
   logic                 overflow_reg;
   logic                 active;
   logic                 start_ok;
   logic                 dec_event;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic                 fifo_full;
   logic                 fifo_empty;
`ifdef SD_DECIM_CTRL_SETTLE_EN
   logic [1:0]           settle_cnt_reg;
`endif

   // Enable divider, decimation detection, buffer handshake and next state
   always_comb begin
      active    = (state_reg != IDLE);
      start_ok  = start && !stop && (state_reg == IDLE);
      en        = active && (div_cnt_reg == div_reg);
      dec_event = en && (phase_reg == PW'(OSR - 1));
      pop       = sampleValid && sampleReady;
      push      = cap_reg && (state_reg == RUN) && (!fifo_full || pop);
      drop      = cap_reg && (state_reg == RUN) && fifo_full && !pop;

      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_ok) begin
`ifdef SD_DECIM_CTRL_SETTLE_EN
               state_next = SETTLE;
`else
               state_next = RUN;
`endif
            end
         end
`ifdef SD_DECIM_CTRL_SETTLE_EN
         SETTLE: begin
            if (stop) begin
               state_next = IDLE;
            end else if (cap_reg && (settle_cnt_reg == 2'(SD_SETTLE_COUNT - 1))) begin
               state_next = RUN;
            end
         end
`endif
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, divider/phase counters, capture strobe and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         div_reg      <= '0;
         div_cnt_reg  <= '0;
         phase_reg    <= '0;
         cap_reg      <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         // a stop in a decimation cycle cancels the pending capture
         cap_reg   <= dec_event && !stop;

         if (start_ok) begin
            div_reg      <= div;
            overflow_reg <= 1'b0;
         end else if (drop) begin
            overflow_reg <= 1'b1;
         end

         // counters sit at zero in IDLE so the first en lands on cycle div+1
         if ((state_reg == IDLE) || (state_next == IDLE)) begin
            div_cnt_reg <= '0;
            phase_reg   <= '0;
         end else if (en) begin
            div_cnt_reg <= '0;
            phase_reg   <= phase_reg + 1'b1;
         end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
         end
      end
   end

`ifdef SD_DECIM_CTRL_SETTLE_EN
   // Count captures discarded while the filter output is still settling
   always_ff @(posedge clk) begin
      if (rst || (state_reg != SETTLE)) begin
         settle_cnt_reg <= '0;
      end else if (cap_reg) begin
         settle_cnt_reg <= settle_cnt_reg + 1'b1;
      end
   end
`endif

   sd_sample_fifo #(
      .WIDTH (FILT_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (filtIn),
      .dout  (sampleOut),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign sampleValid = !fifo_empty;
   assign busy        = active;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_sd_decim_ctrl.sv
// Directed self-checking bench for sd_decim_ctrl (OSR=32).
// filtIn carries the 0-based capture index, so every buffered sample value and
// its arrival cycle are known in advance from the start cycle and divider.
module tb_sd_decim_ctrl;

   localparam int OSR = 32;
   localparam int FW  = 16;
   localparam int DW  = 8;
`ifdef SD_DECIM_CTRL_SETTLE_EN
   localparam int SKIP = 3;
`else
   localparam int SKIP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [DW-1:0] div;
   logic [FW-1:0] filtIn;
   logic          en;
   logic [FW-1:0] sampleOut;
   logic          sampleValid;
   logic          sampleReady;
   logic          busy;
   logic          overflow;

   int tests = 0;
   int fails = 0;
   int rel   = 0;   // cycles since the cycle in which start was asserted
   int per   = 1;   // en period the bench expects (div + 1)

   always #5 clk = ~clk;

   sd_decim_ctrl #(
      .OSR        (OSR),
      .FILT_WIDTH (FW),
      .DIV_WIDTH  (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .div         (div),
      .filtIn      (filtIn),
      .en          (en),
      .sampleOut   (sampleOut),
      .sampleValid (sampleValid),
      .sampleReady (sampleReady),
      .busy        (busy),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, rel);
         $error("check %s", tag);
      end
   endtask

   // advance one cycle; filtIn in cycle n is the index of a capture taken in n
   task automatic tick();
      @(posedge clk);
      #1;
      rel++;
      filtIn = FW'((rel - 1) / (OSR * per) - 1);
   endtask

   task automatic run_to(input int target);
      while (rel < target) tick();
   endtask

   task automatic do_start(input int d);
      start = 1'b1;
      div   = DW'(d);
      per   = d + 1;
      rel   = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; div = '0; filtIn = '0; sampleReady = 1'b0;
      #1;
      tick(); tick();
      chk("rst_en", en, 0);
      chk("rst_valid", sampleValid, 0);
      chk("rst_out", sampleOut, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;
      tick();

      // basic flow, div=0, consumer always ready
      sampleReady = 1'b1;
      do_start(0);
      chk("t1_busy", busy, 1);
      chk("t1_en_first", en, 1);
      run_to(OSR * (SKIP + 1) + 1);
      chk("t1_valid_early", sampleValid, 0);
      tick();
      chk("t1_valid", sampleValid, 1);
      chk("t1_out0", sampleOut, SKIP);
      tick();
      chk("t1_popped", sampleValid, 0);
      run_to(OSR * (SKIP + 2) + 2);
      chk("t1_valid2", sampleValid, 1);
      chk("t1_out1", sampleOut, SKIP + 1);
      do_stop();
      chk("t1_stop_busy", busy, 0);
      chk("t1_stop_en", en, 0);
      tick();

      // div=3: en one cycle in four; div changed mid-run must not matter
      do_start(3);
      run_to(3);
      chk("t2_en_c3", en, 0);
      tick();
      chk("t2_en_c4", en, 1);
      tick();
      chk("t2_en_c5", en, 0);
      run_to(128 * SKIP + 10);
      div = '0;
      run_to(128 * SKIP + 12);
      chk("t2_en_hold", en, 1);
      tick();
      chk("t2_en_gap", en, 0);
      run_to(128 * (SKIP + 1) + 1);
      chk("t2_valid_early", sampleValid, 0);
      tick();
      chk("t2_valid", sampleValid, 1);
      chk("t2_out", sampleOut, SKIP);
      do_stop();
      tick();

      // backpressure: two held, later captures dropped, overflow sticky
      sampleReady = 1'b0;
      do_start(0);
      run_to(OSR * (SKIP + 3) + 1);
      chk("t3_ovf_pre", overflow, 0);
      tick();
      chk("t3_ovf_set", overflow, 1);
      run_to(OSR * (SKIP + 4) + 5);
      do_stop();
      chk("t3_busy", busy, 0);
      chk("t3_held_valid", sampleValid, 1);
      chk("t3_held_out", sampleOut, SKIP);
      sampleReady = 1'b1;
      tick();
      chk("t3_drain_valid", sampleValid, 1);
      chk("t3_drain_out", sampleOut, SKIP + 1);
      tick();
      chk("t3_empty", sampleValid, 0);
      chk("t3_ovf_sticky", overflow, 1);
      sampleReady = 1'b0;

      // stop coinciding with a decimation en
      do_start(0);
      chk("t4_ovf_clr", overflow, 0);
      run_to(OSR * (SKIP + 3));
      chk("t4_dec_en", en, 1);
      chk("t4_head", sampleOut, SKIP);
      stop = 1'b1;
      sampleReady = 1'b1;
      tick();
      stop = 1'b0;
      chk("t4_en_off", en, 0);
      chk("t4_busy", busy, 0);
      chk("t4_valid", sampleValid, 1);
      chk("t4_order", sampleOut, SKIP + 1);
      tick();
      chk("t4_no_push", sampleValid, 0);
      chk("t4_ovf", overflow, 0);

      // start+stop from IDLE does nothing; start during RUN ignored
      start = 1'b1; stop = 1'b1; div = '0;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("t5_ss_busy", busy, 0);
      chk("t5_ss_en", en, 0);
      do_start(0);
      run_to(OSR * (SKIP + 1) + 5);
      start = 1'b1; div = DW'(3);
      tick();
      start = 1'b0;
      run_to(OSR * (SKIP + 2) + 2);
      chk("t5_valid", sampleValid, 1);
      chk("t5_out", sampleOut, SKIP + 1);
      chk("t5_en", en, 1);
      do_stop();
      tick();

      // reset mid-run with one buffered sample
      sampleReady = 1'b0;
      do_start(0);
      run_to(OSR * (SKIP + 1) + 3);
      chk("t6_buffered", sampleValid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_en", en, 0);
      chk("t6_valid", sampleValid, 0);
      chk("t6_out", sampleOut, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ovf", overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
